// File: rtl/scroll_msg_ctrl.sv
// Message buffer and scroll controller feeding an 8-digit seven-segment driver.
// Holds up to MSG_LEN 4-bit codes and presents a registered 8-character window.
module scroll_msg_ctrl #(
    parameter int DIV_W   = 24,
    parameter int MSG_LEN = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic        wr_en,
    input  logic [3:0]  wr_data,
    output logic        wr_ready,
    input  logic        run,
    input  logic        dir,
    output logic [31:0] digits,
    output logic        step
);

    localparam int LW = $clog2(MSG_LEN + 1);
    localparam int OW = $clog2(MSG_LEN);
    localparam int JW = LW + 1;

    typedef enum logic {IDLE, SCROLL} state_t;

    state_t             state;
    logic [LW-1:0]      len;
    logic [OW-1:0]      offset;
    logic [DIV_W-1:0]   presc;
    logic [3:0]         msg_buf [MSG_LEN];
    logic [31:0]        win;
    logic [JW-1:0]      j;
    logic               tick;
    logic               wr_fire;

    assign wr_ready = (state == IDLE) && !run;
    assign tick     = (presc == '1);
    assign wr_fire  = wr_ready && wr_en && !clr && (len != LW'(MSG_LEN));

    always_ff @(posedge clk) begin
        if (wr_fire)
            msg_buf[OW'(len)] <= wr_data;
    end

    // Short messages are left-aligned and padded with blanks; offset is ignored.
    always_comb begin
        win = '1;
        j   = '0;
        for (int unsigned i = 0; i < 8; i++) begin
            if (len >= LW'(8)) begin
                j = JW'(offset) + JW'(i);
                if (j >= JW'(len))
                    j = j - JW'(len);
                win[(7 - i) * 4 +: 4] = msg_buf[OW'(j)];
            end else if (LW'(i) < len) begin
                win[(7 - i) * 4 +: 4] = msg_buf[OW'(i)];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            len    <= '0;
            offset <= '0;
            presc  <= '0;
            step   <= 1'b0;
            digits <= '1;
        end else begin
            digits <= win;
            step   <= 1'b0;
            if (clr) begin
                state  <= IDLE;
                len    <= '0;
                offset <= '0;
                presc  <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        presc <= '0;
                        if (run && len >= LW'(8))
                            state <= SCROLL;
                        else if (wr_fire)
                            len <= len + LW'(1);
                    end
                    SCROLL: begin
                        if (!run) begin
                            state <= IDLE;
                            presc <= '0;
                        end else begin
                            presc <= presc + DIV_W'(1);
                            if (tick) begin
                                step <= 1'b1;
                                if (!dir)
                                    offset <= (LW'(offset) == len - LW'(1)) ? '0 : offset + OW'(1);
                                else
                                    offset <= (offset == '0) ? OW'(len - LW'(1)) : offset - OW'(1);
                            end
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_scroll_msg_ctrl.sv
// Self-checking bench for scroll_msg_ctrl: a message-level model checked every cycle
// plus directed literal expectations at key points of each scenario.
module tb_scroll_msg_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        clr = 1'b0;
    logic        wr_en = 1'b0;
    logic [3:0]  wr_data = '0;
    logic        wr_ready;
    logic        run = 1'b0;
    logic        dir = 1'b0;
    logic [31:0] digits;
    logic        step;

    int tests = 0;
    int fails = 0;

    scroll_msg_ctrl #(.DIV_W(4), .MSG_LEN(16)) dut (
        .clk(clk), .rst(rst), .clr(clr), .wr_en(wr_en), .wr_data(wr_data),
        .wr_ready(wr_ready), .run(run), .dir(dir), .digits(digits), .step(step)
    );

    always #5 clk = ~clk;

    // Model: message contents, length, offset, scroll flag and cycle count within a step period.
    logic [3:0]  msg [16];
    int          mlen = 0;
    int          moff = 0;
    bit          scrolling = 0;
    int          cnt = 0;
    logic [31:0] exp_digits = '1;
    logic        exp_step = 1'b0;

    function automatic logic [31:0] model_win();
        logic [31:0] w;
        w = '1;
        for (int i = 0; i < 8; i++) begin
            if (mlen >= 8)
                w[(7 - i) * 4 +: 4] = msg[(moff + i) % mlen];
            else if (i < mlen)
                w[(7 - i) * 4 +: 4] = msg[i];
        end
        return w;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mlen = 0; moff = 0; scrolling = 0; cnt = 0;
            exp_digits = '1; exp_step = 1'b0;
        end else begin
            exp_digits = model_win();
            exp_step   = 1'b0;
            if (clr) begin
                mlen = 0; moff = 0; scrolling = 0; cnt = 0;
            end else if (!scrolling) begin
                cnt = 0;
                if (run && mlen >= 8)
                    scrolling = 1;
                else if (!run && wr_en && mlen < 16) begin
                    msg[mlen] = wr_data;
                    mlen++;
                end
            end else if (!run) begin
                scrolling = 0; cnt = 0;
            end else begin
                cnt = (cnt + 1) % 16;
                if (cnt == 0) begin
                    exp_step = 1'b1;
                    moff = dir ? (moff + mlen - 1) % mlen : (moff + 1) % mlen;
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            check("model digits", digits, exp_digits);
            check("model step", 32'(step), 32'(exp_step));
            check("model wr_ready", 32'(wr_ready), 32'(!scrolling && !run));
        end
    end

    task automatic cyc(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic write_char(input logic [3:0] c);
        wr_en = 1'b1;
        wr_data = c;
        cyc(1);
        wr_en = 1'b0;
    endtask

    // Returns the number of edges until step is seen, 0 if none within the budget.
    task automatic wait_step(output int n);
        n = 0;
        for (int k = 1; k <= 40; k++) begin
            cyc(1);
            if (step === 1'b1) begin
                n = k;
                break;
            end
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        cyc(3);
        check("reset digits", digits, 32'hFFFF_FFFF);
        check("reset step", 32'(step), 32'd0);
        check("reset wr_ready", 32'(wr_ready), 32'd1);
        rst = 1'b0;
        cyc(2);

        run = 1'b1;
        cyc(20);
        check("empty run digits", digits, 32'hFFFF_FFFF);
        check("empty run wr_ready", 32'(wr_ready), 32'd0);
        run = 1'b0;
        cyc(1);

        write_char(4'h1); write_char(4'h2); write_char(4'h3);
        run = 1'b1;
        cyc(3);
        check("short digits", digits, 32'h123F_FFFF);
        cyc(64);
        check("short digits held", digits, 32'h123F_FFFF);
        check("short wr_ready", 32'(wr_ready), 32'd0);
        run = 1'b0;
        clr = 1'b1;
        cyc(1);
        clr = 1'b0;

        for (int k = 0; k < 10; k++) write_char(4'(k));
        cyc(2);
        check("left initial", digits, 32'h0123_4567);
        run = 1'b1; dir = 1'b0;
        wait_step(n);
        check("first step latency", 32'(n), 32'd17);
        cyc(1);
        check("left step1", digits, 32'h1234_5678);
        wait_step(n); check("step2 latency", 32'(n), 32'd15);
        wait_step(n); check("step3 latency", 32'(n), 32'd16);
        cyc(1);
        check("left step3", digits, 32'h3456_7890);
        wait_step(n); check("step4 latency", 32'(n), 32'd15);
        for (int k = 5; k <= 10; k++) begin
            wait_step(n);
            check("step latency", 32'(n), 32'd16);
        end
        cyc(1);
        check("left step10 wrap", digits, 32'h0123_4567);
        dir = 1'b1;
        wait_step(n); check("right step latency", 32'(n), 32'd15);
        cyc(1);
        check("right step", digits, 32'h9012_3456);

        run = 1'b0;
        cyc(2);
        clr = 1'b1; cyc(1); clr = 1'b0;
        dir = 1'b0;
        for (int k = 0; k < 16; k++) write_char(4'(k % 8));
        write_char(4'hC);
        cyc(2);
        check("overflow initial", digits, 32'h0123_4567);
        run = 1'b1;
        wait_step(n); check("overflow step latency", 32'(n), 32'd17);
        cyc(1);
        check("overflow step1", digits, 32'h1234_5670);
        run = 1'b0;
        cyc(30);
        check("paused digits", digits, 32'h1234_5670);
        run = 1'b1;
        wait_step(n); check("resume latency", 32'(n), 32'd17);
        cyc(1);
        check("resumed digits", digits, 32'h2345_6701);

        cyc(5);
        clr = 1'b1; wr_en = 1'b1; wr_data = 4'h3;
        cyc(1);
        clr = 1'b0; wr_en = 1'b0;
        cyc(1);
        check("clr digits", digits, 32'hFFFF_FFFF);
        check("clr wr_ready", 32'(wr_ready), 32'd0);
        run = 1'b0;
        #1;
        check("clr idle wr_ready", 32'(wr_ready), 32'd1);

        cyc(1);
        for (int k = 0; k < 8; k++) write_char(4'(k + 1));
        run = 1'b1;
        wait_step(n); check("pre-reset step latency", 32'(n), 32'd17);
        #1;
        rst = 1'b1; run = 1'b0;
        #1;
        check("async rst digits", digits, 32'hFFFF_FFFF);
        check("async rst step", 32'(step), 32'd0);
        check("async rst wr_ready", 32'(wr_ready), 32'd1);
        cyc(2);
        rst = 1'b0;
        cyc(3);
        check("post reset digits", digits, 32'hFFFF_FFFF);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
